// File: rtl/axi_arbiter_w_if.sv
// AXI4 write-channel bundle (AW, W, B) used on both sides of the write arbiter.
//   master modport : drives AW/W requests and BREADY; receives AWREADY, WREADY and B.
//   slave  modport : the opposite direction.
// WLAST is part of the bundle in both directions.
interface axi_arbiter_w_if #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [USER_WIDTH-1:0] awuser;
    logic                  awvalid;
    logic                  awready;
    // write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic [USER_WIDTH-1:0] wuser;
    logic                  wvalid;
    logic                  wready;
    // write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic [USER_WIDTH-1:0] buser;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output wdata, wstrb, wlast, wuser, wvalid,
        output bready,
        input  awready, wready, bid, bresp, buser, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  wdata, wstrb, wlast, wuser, wvalid,
        input  bready,
        output awready, wready, bid, bresp, buser, bvalid
    );
endinterface

// File: rtl/axi_arbiter_w.sv
// Two-master AXI4 write-channel arbiter with round-robin priority.
// One write transaction (AW, all W beats, B) is granted to one master at a time;
// only one write is ever outstanding. The downstream WLAST is generated from a
// beat counter against the latched AWLEN, and a master WLAST that disagrees with
// the count raises a one-cycle wlast_err pulse.
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   s0, s1        : upstream masters (slave side of the bundle)
//   s2m           : forwarded request towards the write slave mux (master side)
//   wlast_err     : one-cycle pulse after a W handshake with a wrong master WLAST
module axi_arbiter_w (
    input  logic            ACLK,
    input  logic            ARESETn,
    axi_arbiter_w_if.slave  s0,
    axi_arbiter_w_if.slave  s1,
    axi_arbiter_w_if.master s2m,
    output logic            wlast_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t     state_reg;
    logic       grant_reg;      // master currently owning the channel
    logic       prio_reg;       // master favoured when both request together
    logic [7:0] len_q_reg;
    logic [7:0] beat_cnt_reg;
    logic       wlast_err_reg;

    logic       in_addr, in_data, in_resp;
    logic       sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic [7:0] sel_awlen;
    logic       aw_on, w_on, last_beat;
    logic       aw_hs, w_hs, b_hs;

    assign in_addr = (state_reg == ST_ADDR);
    assign in_data = (state_reg == ST_DATA);
    assign in_resp = (state_reg == ST_RESP);

    assign sel_awvalid = grant_reg ? s1.awvalid : s0.awvalid;
    assign sel_awlen   = grant_reg ? s1.awlen   : s0.awlen;
    assign sel_wvalid  = grant_reg ? s1.wvalid  : s0.wvalid;
    assign sel_wlast   = grant_reg ? s1.wlast   : s0.wlast;
    assign sel_bready  = grant_reg ? s1.bready  : s0.bready;

    // Forwarded valids exist only in the owning phase; payload is zeroed otherwise.
    assign aw_on     = in_addr & sel_awvalid;
    assign w_on      = in_data & sel_wvalid;
    assign last_beat = (beat_cnt_reg == len_q_reg);

    assign aw_hs = aw_on & s2m.awready;
    assign w_hs  = w_on & s2m.wready;
    assign b_hs  = in_resp & s2m.bvalid & sel_bready;

    // ---------------- downstream AW ----------------
    assign s2m.awvalid  = aw_on;
    assign s2m.awid     = aw_on ? (grant_reg ? s1.awid     : s0.awid)     : '0;
    assign s2m.awaddr   = aw_on ? (grant_reg ? s1.awaddr   : s0.awaddr)   : '0;
    assign s2m.awlen    = aw_on ? sel_awlen                               : '0;
    assign s2m.awsize   = aw_on ? (grant_reg ? s1.awsize   : s0.awsize)   : '0;
    assign s2m.awburst  = aw_on ? (grant_reg ? s1.awburst  : s0.awburst)  : '0;
    assign s2m.awlock   = aw_on ? (grant_reg ? s1.awlock   : s0.awlock)   : 1'b0;
    assign s2m.awcache  = aw_on ? (grant_reg ? s1.awcache  : s0.awcache)  : '0;
    assign s2m.awprot   = aw_on ? (grant_reg ? s1.awprot   : s0.awprot)   : '0;
    assign s2m.awqos    = aw_on ? (grant_reg ? s1.awqos    : s0.awqos)    : '0;
    assign s2m.awregion = aw_on ? (grant_reg ? s1.awregion : s0.awregion) : '0;
    assign s2m.awuser   = aw_on ? (grant_reg ? s1.awuser   : s0.awuser)   : '0;

    // ---------------- downstream W -----------------
    // WLAST comes from the beat count, never from the master.
    assign s2m.wvalid = w_on;
    assign s2m.wdata  = w_on ? (grant_reg ? s1.wdata : s0.wdata) : '0;
    assign s2m.wstrb  = w_on ? (grant_reg ? s1.wstrb : s0.wstrb) : '0;
    assign s2m.wuser  = w_on ? (grant_reg ? s1.wuser : s0.wuser) : '0;
    assign s2m.wlast  = w_on & last_beat;

    // ---------------- downstream B ready -----------
    assign s2m.bready = in_resp & sel_bready;

    // ---------------- upstream handshakes ----------
    assign s0.awready = in_addr & ~grant_reg & s2m.awready;
    assign s0.wready  = in_data & ~grant_reg & s2m.wready;
    assign s0.bvalid  = in_resp & ~grant_reg & s2m.bvalid;
    assign s0.bid     = (in_resp & ~grant_reg) ? s2m.bid   : '0;
    assign s0.bresp   = (in_resp & ~grant_reg) ? s2m.bresp : '0;
    assign s0.buser   = (in_resp & ~grant_reg) ? s2m.buser : '0;

    assign s1.awready = in_addr & grant_reg & s2m.awready;
    assign s1.wready  = in_data & grant_reg & s2m.wready;
    assign s1.bvalid  = in_resp & grant_reg & s2m.bvalid;
    assign s1.bid     = (in_resp & grant_reg) ? s2m.bid   : '0;
    assign s1.bresp   = (in_resp & grant_reg) ? s2m.bresp : '0;
    assign s1.buser   = (in_resp & grant_reg) ? s2m.buser : '0;

    assign wlast_err = wlast_err_reg;

    // ---------------- control FSM ------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 1'b0;
            prio_reg      <= 1'b0;
            len_q_reg     <= 8'd0;
            beat_cnt_reg  <= 8'd0;
            wlast_err_reg <= 1'b0;
        end else begin
            wlast_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s0.awvalid | s1.awvalid) begin
                        // Sole requester wins; on a tie the favoured master wins.
                        grant_reg <= (s0.awvalid & s1.awvalid) ? prio_reg : s1.awvalid;
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) begin
                        len_q_reg    <= sel_awlen;
                        beat_cnt_reg <= 8'd0;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_cnt_reg  <= beat_cnt_reg + 8'd1;
                        wlast_err_reg <= sel_wlast ^ last_beat;
                        // The burst always ends on the count, whatever the master's WLAST says.
                        if (last_beat) begin
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        prio_reg  <= ~grant_reg;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_arbiter_w.sv
module tb_axi_arbiter_w;
    localparam int DW    = 64;
    localparam int LIMIT = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_arbiter_w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(8)) m_if [2] ();
    axi_arbiter_w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(8)) s2m_if ();
    logic wlast_err;

    axi_arbiter_w dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .s0        (m_if[0]),
        .s1        (m_if[1]),
        .s2m       (s2m_if),
        .wlast_err (wlast_err)
    );

    // ---------------- bench-driven signals ----------------
    logic [1:0]  m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [63:0] m_awaddr [2];
    logic [7:0]  m_awlen  [2];
    logic [7:0]  m_awid   [2];
    logic [63:0] m_wdata  [2];
    logic [1:0]  o_awready, o_wready, o_bvalid;
    logic [1:0]  o_bresp  [2];
    logic [7:0]  o_bid    [2];

    logic        ds_awready, ds_wready, ds_bvalid;
    logic [1:0]  ds_bresp;
    logic [7:0]  ds_bid;
    logic        wr_toggle;
    int          b_delay;
    logic [3:0]  wr_pat = 4'b1001;

    for (genvar gi = 0; gi < 2; gi++) begin : g_m
        assign m_if[gi].awvalid  = m_awvalid[gi];
        assign m_if[gi].awaddr   = m_awaddr[gi];
        assign m_if[gi].awlen    = m_awlen[gi];
        assign m_if[gi].awid     = m_awid[gi];
        assign m_if[gi].awsize   = 3'd3;
        assign m_if[gi].awburst  = 2'b01;
        assign m_if[gi].awlock   = 1'b0;
        assign m_if[gi].awcache  = 4'd0;
        assign m_if[gi].awprot   = 3'd0;
        assign m_if[gi].awqos    = 4'd0;
        assign m_if[gi].awregion = 4'd0;
        assign m_if[gi].awuser   = 8'd0;
        assign m_if[gi].wvalid   = m_wvalid[gi];
        assign m_if[gi].wdata    = m_wdata[gi];
        assign m_if[gi].wstrb    = '1;
        assign m_if[gi].wlast    = m_wlast[gi];
        assign m_if[gi].wuser    = 8'd0;
        assign m_if[gi].bready   = m_bready[gi];
        assign o_awready[gi]     = m_if[gi].awready;
        assign o_wready[gi]      = m_if[gi].wready;
        assign o_bvalid[gi]      = m_if[gi].bvalid;
        assign o_bresp[gi]       = m_if[gi].bresp;
        assign o_bid[gi]         = m_if[gi].bid;
    end

    assign s2m_if.awready = ds_awready;
    assign s2m_if.wready  = ds_wready;
    assign s2m_if.bvalid  = ds_bvalid;
    assign s2m_if.bresp   = ds_bresp;
    assign s2m_if.bid     = ds_bid;
    assign s2m_if.buser   = 8'd0;

    // ---------------- checking helpers ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s cyc=%0d got=timeout expected=handshake", name, cyc);
    endtask

    // ---------------- transaction-level model + statistics ----------------
    // Model: who owns the channel (-1 = nobody), whether its address went out,
    // how many data beats remain, and who is favoured next.
    int   own = -1;
    bit   addr_done;
    int   beats_left;
    bit   prio_m;
    bit   err_m;

    int   grants[$];
    int   beats_m[2];
    int   aw_cyc[2];
    int   b_cyc[2];
    int   wlast_hs, err_pulses, viol;
    int   rise0, fwd0;
    bit   prev_awv0, prev_s2m_awv;

    task automatic clear_stats();
        grants.delete();
        beats_m = '{0, 0};
        aw_cyc  = '{0, 0};
        b_cyc   = '{0, 0};
        wlast_hs = 0; err_pulses = 0; viol = 0; rise0 = -1; fwd0 = -1;
    endtask

    initial begin : model
        int  o;
        bit  ph_addr, ph_data, ph_resp, aw_fwd, w_fwd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                own = -1; addr_done = 0; beats_left = 0; prio_m = 0; err_m = 0;
            end
            o       = (own < 0) ? 0 : own;
            ph_addr = (own >= 0) && !addr_done;
            ph_data = (own >= 0) && addr_done && (beats_left > 0);
            ph_resp = (own >= 0) && addr_done && (beats_left == 0);
            aw_fwd  = ph_addr && m_awvalid[o];
            w_fwd   = ph_data && m_wvalid[o];

            chk("s2m_awvalid", 64'(s2m_if.awvalid), 64'(aw_fwd));
            chk("s2m_awaddr",  s2m_if.awaddr, aw_fwd ? m_awaddr[o] : 64'd0);
            chk("s2m_awlen",   64'(s2m_if.awlen), aw_fwd ? 64'(m_awlen[o]) : 64'd0);
            chk("s2m_awid",    64'(s2m_if.awid),  aw_fwd ? 64'(m_awid[o])  : 64'd0);
            chk("s2m_wvalid",  64'(s2m_if.wvalid), 64'(w_fwd));
            chk("s2m_wdata",   s2m_if.wdata, w_fwd ? m_wdata[o] : 64'd0);
            chk("s2m_wlast",   64'(s2m_if.wlast), 64'(w_fwd && beats_left == 1));
            chk("s2m_bready",  64'(s2m_if.bready), 64'(ph_resp && m_bready[o]));
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("s%0d_awready", m), 64'(o_awready[m]), 64'(ph_addr && o == m && ds_awready));
                chk($sformatf("s%0d_wready", m),  64'(o_wready[m]),  64'(ph_data && o == m && ds_wready));
                chk($sformatf("s%0d_bvalid", m),  64'(o_bvalid[m]),  64'(ph_resp && o == m && ds_bvalid));
                chk($sformatf("s%0d_bresp", m),   64'(o_bresp[m]),   (ph_resp && o == m) ? 64'(ds_bresp) : 64'd0);
                chk($sformatf("s%0d_bid", m),     64'(o_bid[m]),     (ph_resp && o == m) ? 64'(ds_bid)   : 64'd0);
            end
            chk("wlast_err", 64'(wlast_err), 64'(err_m));

            if (rst_n) begin
                // statistics observed on the DUT ports
                for (int m = 0; m < 2; m++) begin
                    if (m_awvalid[m] && o_awready[m]) begin grants.push_back(m); aw_cyc[m] = cyc; end
                    if (m_wvalid[m] && o_wready[m]) beats_m[m]++;
                    if (o_bvalid[m] && m_bready[m]) b_cyc[m] = cyc;
                end
                if (s2m_if.wvalid && ds_wready && s2m_if.wlast) wlast_hs++;
                if (wlast_err) err_pulses++;
                if (own == 0 && o_wready[1]) viol++;
                if (m_awvalid[0] && !prev_awv0 && rise0 < 0) rise0 = cyc;
                if (s2m_if.awvalid && !prev_s2m_awv && fwd0 < 0) fwd0 = cyc;

                // advance the model across the coming edge
                err_m = 0;
                if (own < 0) begin
                    if (m_awvalid[0] && m_awvalid[1]) own = prio_m ? 1 : 0;
                    else if (m_awvalid[0])            own = 0;
                    else if (m_awvalid[1])            own = 1;
                    addr_done = 0;
                end else if (!addr_done) begin
                    if (m_awvalid[o] && ds_awready) begin
                        addr_done  = 1;
                        beats_left = int'(m_awlen[o]) + 1;
                    end
                end else if (beats_left > 0) begin
                    if (m_wvalid[o] && ds_wready) begin
                        err_m = (m_wlast[o] != (beats_left == 1));
                        beats_left--;
                    end
                end else if (ds_bvalid && m_bready[o]) begin
                    prio_m = (o == 0);
                    own    = -1;
                end
            end
            prev_awv0    = m_awvalid[0];
            prev_s2m_awv = s2m_if.awvalid;
        end
    end

    // ---------------- downstream responder ----------------
    initial begin : wready_drv
        forever begin
            @(posedge clk); #1;
            ds_wready = wr_toggle ? wr_pat[3 - (cyc % 4)] : 1'b1;
        end
    end

    initial begin : b_responder
        int g;
        forever begin
            @(negedge clk);
            if (rst_n && s2m_if.wvalid && ds_wready && s2m_if.wlast) begin
                @(posedge clk); #1;
                for (int i = 0; i < b_delay; i++) begin @(posedge clk); #1; end
                ds_bvalid = 1'b1; ds_bresp = 2'b01; ds_bid = 8'h5A;
                g = 0;
                do begin @(negedge clk); g++; end while (!s2m_if.bready && g < LIMIT && rst_n);
                if (g >= LIMIT) timeout_fail("b_accept");
                @(posedge clk); #1;
                ds_bvalid = 1'b0; ds_bresp = 2'b00; ds_bid = 8'h00;
            end
        end
    end

    // ---------------- master driver ----------------
    task automatic master_txn(input int m, input logic [63:0] addr, input logic [7:0] len, input int bad_beat);
        int g;
        @(posedge clk); #1;
        m_awvalid[m] = 1'b1; m_awaddr[m] = addr; m_awlen[m] = len; m_awid[m] = 8'(m + 1);
        g = 0;
        do begin @(negedge clk); g++; end while (!o_awready[m] && g < LIMIT);
        if (g >= LIMIT) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        m_awvalid[m] = 1'b0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awid[m] = '0;
        for (int b = 0; b <= int'(len); b++) begin
            m_wvalid[m] = 1'b1;
            m_wdata[m]  = {addr[31:0], 32'(b)};
            m_wlast[m]  = (b == int'(len)) || (b == bad_beat);
            g = 0;
            do begin @(negedge clk); g++; end while (!o_wready[m] && g < LIMIT);
            if (g >= LIMIT) timeout_fail("w_handshake");
            @(posedge clk); #1;
        end
        m_wvalid[m] = 1'b0; m_wdata[m] = '0; m_wlast[m] = 1'b0;
        m_bready[m] = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (!o_bvalid[m] && g < LIMIT);
        if (g >= LIMIT) timeout_fail("b_handshake");
        @(posedge clk); #1;
        m_bready[m] = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int exp_seq [6];
        int g;
        exp_seq = '{0, 1, 0, 1, 0, 1};
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
        for (int m = 0; m < 2; m++) begin
            m_awaddr[m] = '0; m_awlen[m] = '0; m_awid[m] = '0; m_wdata[m] = '0;
        end
        ds_awready = 1'b1; ds_wready = 1'b1; ds_bvalid = 1'b0; ds_bresp = '0; ds_bid = '0;
        wr_toggle = 1'b0; b_delay = 0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Tie straight after reset: s0 first, s1 two cycles after s0's B handshake
        clear_stats();
        fork
            master_txn(0, 64'h2000, 8'd1, -1);
            master_txn(1, 64'h3000, 8'd2, -1);
        join
        chk("tie_count", 64'(grants.size()), 64'd2);
        if (grants.size() >= 2) begin
            chk("tie_first",  64'(grants[0]), 64'd0);
            chk("tie_second", 64'(grants[1]), 64'd1);
        end
        chk("tie_gap", 64'(aw_cyc[1] - b_cyc[0]), 64'd2);
        $display("tie: grants=%p s1_aw_cyc=%0d s0_b_cyc=%0d", grants, aw_cyc[1], b_cyc[0]);

        // Round-robin fairness over six transactions
        clear_stats();
        fork
            for (int i = 0; i < 3; i++) master_txn(0, 64'h100 + 64'(i), 8'd1, -1);
            for (int i = 0; i < 3; i++) master_txn(1, 64'h200 + 64'(i), 8'd0, -1);
        join
        chk("rr_count", 64'(grants.size()), 64'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(exp_seq[i]));
        $display("fairness: grants=%p", grants);

        // Single master, AWLEN=3
        clear_stats();
        master_txn(0, 64'h1000, 8'd3, -1);
        chk("single_latency", 64'(fwd0 - rise0), 64'd1);
        chk("single_beats",   64'(beats_m[0]), 64'd4);
        chk("single_wlast",   64'(wlast_hs), 64'd1);
        $display("single: latency=%0d beats=%0d wlast=%0d", fwd0 - rise0, beats_m[0], wlast_hs);

        // Backpressure: WREADY 1,0,0,1 and B delayed 5, s1 waiting meanwhile
        clear_stats();
        wr_toggle = 1'b1; b_delay = 5;
        fork
            master_txn(0, 64'h7000, 8'd7, -1);
            begin repeat (3) @(posedge clk); master_txn(1, 64'h8000, 8'd1, -1); end
        join
        wr_toggle = 1'b0; b_delay = 0;
        chk("bp_beats_s0", 64'(beats_m[0]), 64'd8);
        chk("bp_beats_s1", 64'(beats_m[1]), 64'd2);
        chk("bp_s1_wready_viol", 64'(viol), 64'd0);
        $display("backpressure: s0_beats=%0d s1_beats=%0d viol=%0d", beats_m[0], beats_m[1], viol);

        // Early master WLAST on beat 2 of 4
        clear_stats();
        master_txn(0, 64'h9000, 8'd3, 1);
        chk("err_pulses", 64'(err_pulses), 64'd1);
        chk("err_beats",  64'(beats_m[0]), 64'd4);
        chk("err_wlast",  64'(wlast_hs), 64'd1);
        $display("wlast_err: pulses=%0d beats=%0d wlast=%0d", err_pulses, beats_m[0], wlast_hs);

        // Reset mid-burst (prio is 1 here), then a tie must favour s0 again
        clear_stats();
        @(posedge clk); #1;
        m_awvalid[0] = 1'b1; m_awaddr[0] = 64'hA000; m_awlen[0] = 8'd5; m_awid[0] = 8'd1;
        g = 0;
        do begin @(negedge clk); g++; end while (!o_awready[0] && g < LIMIT);
        if (g >= LIMIT) timeout_fail("rst_aw_handshake");
        @(posedge clk); #1;
        m_awvalid[0] = 1'b0; m_awaddr[0] = '0; m_awlen[0] = '0;
        for (int b = 0; b < 2; b++) begin
            m_wvalid[0] = 1'b1; m_wdata[0] = 64'hA0 + 64'(b);
            g = 0;
            do begin @(negedge clk); g++; end while (!o_wready[0] && g < LIMIT);
            if (g >= LIMIT) timeout_fail("rst_w_handshake");
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_s2m_wvalid", 64'(s2m_if.wvalid), 64'd0);
        chk("async_s2m_wdata",  s2m_if.wdata, 64'd0);
        chk("async_s0_wready",  64'(o_wready[0]), 64'd0);
        chk("async_s2m_awvalid", 64'(s2m_if.awvalid), 64'd0);
        $display("reset mid-burst: wvalid=%0b s0_wready=%0b", s2m_if.wvalid, o_wready[0]);
        m_wvalid[0] = 1'b0; m_wdata[0] = '0; m_awid[0] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        fork
            master_txn(0, 64'hB000, 8'd0, -1);
            master_txn(1, 64'hC000, 8'd1, -1);
        join
        chk("post_rst_count", 64'(grants.size()), 64'd2);
        if (grants.size() >= 1) chk("post_rst_first", 64'(grants[0]), 64'd0);
        clear_stats();
        master_txn(1, 64'hD000, 8'd2, -1);
        chk("post_rst_s1_beats", 64'(beats_m[1]), 64'd3);
        $display("post reset: s1 beats=%0d", beats_m[1]);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
